// File: rtl/exec_pkg.sv
// Shared definitions for the integer execution unit: default widths, issue/forward packet layout
// and opcode encodings used by execute_unit, reservation stations and the ROB.
package exec_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned TAG_W_DEF  = 6;
  localparam int unsigned OP_W_DEF   = 4;

  localparam int unsigned ISSUE_W = OP_W_DEF + TAG_W_DEF + 2 * DATA_W_DEF;
  localparam int unsigned FWD_W   = 1 + TAG_W_DEF + DATA_W_DEF;

  // Issue packet: {op, rob, valueA, valueB}
  localparam int unsigned ISSUE_B_LSB   = 0;
  localparam int unsigned ISSUE_A_LSB   = DATA_W_DEF;
  localparam int unsigned ISSUE_TAG_LSB = 2 * DATA_W_DEF;
  localparam int unsigned ISSUE_OP_LSB  = 2 * DATA_W_DEF + TAG_W_DEF;

  // Forward packet: {valid, rob, value}
  localparam int unsigned FWD_VALUE_LSB = 0;
  localparam int unsigned FWD_TAG_LSB   = DATA_W_DEF;
  localparam int unsigned FWD_VALID_BIT = DATA_W_DEF + TAG_W_DEF;

  localparam logic [OP_W_DEF-1:0] OP_ADD = 4'd0;
  localparam logic [OP_W_DEF-1:0] OP_SUB = 4'd1;
  localparam logic [OP_W_DEF-1:0] OP_AND = 4'd2;
  localparam logic [OP_W_DEF-1:0] OP_OR  = 4'd3;
  localparam logic [OP_W_DEF-1:0] OP_XOR = 4'd4;
  localparam logic [OP_W_DEF-1:0] OP_SHL = 4'd5;
  localparam logic [OP_W_DEF-1:0] OP_SHR = 4'd6;
  localparam logic [OP_W_DEF-1:0] OP_SLT = 4'd7;
  localparam logic [OP_W_DEF-1:0] OP_MUL = 4'd8;

endpackage

// File: rtl/iterative_multiplier.sv
// Shift-add multiplier retiring one multiplier bit per clock; returns the low DATA_W product bits.
// done_o/product_o are combinational in the final iteration cycle so the caller can register them.
module iterative_multiplier #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] product_o
);

  localparam int unsigned CntW = $clog2(DATA_W);

  logic              busy_q;
  logic [CntW-1:0]   cnt_q;
  logic [DATA_W-1:0] mcand_q;
  logic [DATA_W-1:0] mplier_q;
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] acc_d;

  always_comb begin
    acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  assign busy_o    = busy_q;
  assign done_o    = busy_q && (cnt_q == CntW'(DATA_W - 1));
  assign product_o = acc_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (start_i) begin
      busy_q   <= 1'b1;
      cnt_q    <= '0;
      mcand_q  <= a_i;
      mplier_q <= b_i;
      acc_q    <= '0;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CntW'(1);
      if (done_o) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/execute_unit.sv
// Single-issue integer execution unit: one issue stage, inline ALU, registered forward broadcast.
// Define MUL_EXEC_EN to route opcode 8 through the iterative multiplier (otherwise it returns 0).
module execute_unit
  import exec_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned TAG_W  = TAG_W_DEF,
  parameter int unsigned OP_W   = OP_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic [OP_W+TAG_W+2*DATA_W-1:0] in_operation,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [TAG_W+DATA_W:0]         forward_out
);

  localparam int unsigned TagLsb = 2 * DATA_W;
  localparam int unsigned OpLsb  = 2 * DATA_W + TAG_W;

  logic [OP_W-1:0]   in_op;
  logic [TAG_W-1:0]  in_tag;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;

  assign in_op  = in_operation[OpLsb +: OP_W];
  assign in_tag = in_operation[TagLsb +: TAG_W];
  assign in_a   = in_operation[DATA_W +: DATA_W];
  assign in_b   = in_operation[0 +: DATA_W];

  logic              s1_valid_q;
  logic [OP_W-1:0]   s1_op_q;
  logic [TAG_W-1:0]  s1_tag_q;
  logic [DATA_W-1:0] s1_a_q;
  logic [DATA_W-1:0] s1_b_q;

  logic [TAG_W+DATA_W:0] fwd_q;
  logic [TAG_W+DATA_W:0] fwd_d;
  logic [DATA_W-1:0]     alu_res;
  logic                  accept;
  logic                  alu_done;
  logic                  s1_is_mul;

  assign s1_is_mul = s1_valid_q && (s1_op_q == OP_MUL);

  always_comb begin
    alu_res = '0;
    case (s1_op_q)
      OP_ADD:  alu_res = s1_a_q + s1_b_q;
      OP_SUB:  alu_res = s1_a_q - s1_b_q;
      OP_AND:  alu_res = s1_a_q & s1_b_q;
      OP_OR:   alu_res = s1_a_q | s1_b_q;
      OP_XOR:  alu_res = s1_a_q ^ s1_b_q;
      OP_SHL:  alu_res = s1_a_q << s1_b_q[3:0];
      OP_SHR:  alu_res = s1_a_q >> s1_b_q[3:0];
      OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(s1_a_q) < $signed(s1_b_q))};
      default: alu_res = '0;
    endcase
  end

`ifdef MUL_EXEC_EN
  logic              mul_start;
  logic              mul_busy;
  logic              mul_done;
  logic [DATA_W-1:0] mul_product;
  logic [TAG_W-1:0]  mul_tag_q;

  // A multiply waiting in s1 also blocks issue so it can never queue behind a busy multiplier.
  assign in_ready  = !mul_busy && !s1_is_mul;
  assign mul_start = s1_is_mul && !flush;
  assign alu_done  = s1_valid_q && !s1_is_mul;

  iterative_multiplier #(
    .DATA_W (DATA_W)
  ) u_mul (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .clear_i   (flush),
    .start_i   (mul_start),
    .a_i       (s1_a_q),
    .b_i       (s1_b_q),
    .busy_o    (mul_busy),
    .done_o    (mul_done),
    .product_o (mul_product)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mul_tag_q <= '0;
    end else if (mul_start) begin
      mul_tag_q <= s1_tag_q;
    end
  end
`else
  assign in_ready = 1'b1;
  assign alu_done = s1_valid_q;
`endif

  assign accept = in_valid && in_ready && !flush;

  // ALU and multiplier completions never coincide: issue is closed while the multiplier runs.
  always_comb begin
    fwd_d = '0;
    if (alu_done) begin
      fwd_d = {1'b1, s1_tag_q, alu_res};
    end
`ifdef MUL_EXEC_EN
    else if (mul_done) begin
      fwd_d = {1'b1, mul_tag_q, mul_product};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      s1_valid_q <= 1'b0;
      fwd_q      <= '0;
    end else begin
      s1_valid_q <= accept;
      fwd_q      <= fwd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_op_q  <= '0;
      s1_tag_q <= '0;
      s1_a_q   <= '0;
      s1_b_q   <= '0;
    end else if (accept) begin
      s1_op_q  <= in_op;
      s1_tag_q <= in_tag;
      s1_a_q   <= in_a;
      s1_b_q   <= in_b;
    end
  end

  assign forward_out = fwd_q;

endmodule

// File: tb/tb_execute_unit.sv
// Self-checking bench for execute_unit: directed table, hand sequences and random traffic
// against a cycle-level reference model. Multiplier checks follow MUL_EXEC_EN.
module tb_execute_unit;
  import exec_pkg::*;

  localparam int unsigned DW = DATA_W_DEF;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [41:0] in_operation;
  logic        in_valid;
  logic        in_ready;
  logic [22:0] forward_out;

  execute_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_operation (in_operation),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .forward_out  (forward_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  bit          m_pend;
  logic [3:0]  m_op;
  logic [5:0]  m_tag;
  logic [15:0] m_a;
  logic [15:0] m_b;
  int          m_mul_left;
  logic [5:0]  m_mul_tag;
  logic [15:0] m_mul_res;
  logic [22:0] m_fwd;
  bit          m_ready;

  typedef struct {
    logic [3:0]  op;
    logic [5:0]  tag;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_val;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_alu(input logic [3:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
    longint ia, ib, sa, sb, r;
    ia = longint'(a);
    ib = longint'(b);
    sa = (ia >= 32768) ? ia - 65536 : ia;
    sb = (ib >= 32768) ? ib - 65536 : ib;
    case (op)
      4'd0:    r = ia + ib;
      4'd1:    r = ia - ib + 65536;
      4'd2:    r = longint'(a & b);
      4'd3:    r = longint'(a | b);
      4'd4:    r = longint'(a ^ b);
      4'd5:    r = ia * (longint'(1) << (ib % 16));
      4'd6:    r = ia / (longint'(1) << (ib % 16));
      4'd7:    r = (sa < sb) ? 1 : 0;
      default: r = 0;
    endcase
    return 16'(r % 65536);
  endfunction

  // One clock: drive inputs, advance the model across the edge, compare just after it.
  task automatic step(input bit v, input logic [3:0] op, input logic [5:0] tag,
                      input logic [15:0] a, input logic [15:0] b, input bit fl, input bit rs);
    bit acc;
    in_valid     = v;
    in_operation = {op, tag, a, b};
    flush        = fl;
    rst_n        = !rs;
    acc = v && m_ready && !fl && !rs;
    @(posedge clk);
    if (rs || fl) begin
      m_pend     = 1'b0;
      m_mul_left = 0;
      m_fwd      = '0;
    end else begin
      m_fwd = '0;
      if (m_mul_left > 0) begin
        m_mul_left--;
        if (m_mul_left == 0) m_fwd = {1'b1, m_mul_tag, m_mul_res};
      end
      if (m_pend) begin
`ifdef MUL_EXEC_EN
        if (m_op == 4'd8) begin
          m_mul_left = DW;
          m_mul_tag  = m_tag;
          m_mul_res  = 16'((longint'(m_a) * longint'(m_b)) % 65536);
        end else
`endif
        m_fwd = {1'b1, m_tag, ref_alu(m_op, m_a, m_b)};
      end
      m_pend = acc;
      if (acc) begin
        m_op  = op;
        m_tag = tag;
        m_a   = a;
        m_b   = b;
      end
    end
    m_ready = 1'b1;
`ifdef MUL_EXEC_EN
    m_ready = (m_mul_left == 0) && !(m_pend && m_op == 4'd8);
`endif
    #1;
    check("model_fwd", 32'(forward_out), 32'(m_fwd));
    check("model_rdy", 32'(in_ready), 32'(m_ready));
  endtask

  task automatic idle();
    step(1'b0, 4'd0, 6'd0, 16'h0, 16'h0, 1'b0, 1'b0);
  endtask

  initial begin
    m_pend = 0; m_op = '0; m_tag = '0; m_a = '0; m_b = '0;
    m_mul_left = 0; m_mul_tag = '0; m_mul_res = '0; m_fwd = '0; m_ready = 1;

    tbl.push_back('{4'd0,  6'd5,  16'h7FFF, 16'h0001, 16'h8000});
    tbl.push_back('{4'd0,  6'd7,  16'hFFFF, 16'h0001, 16'h0000});
    tbl.push_back('{4'd1,  6'd1,  16'h0003, 16'h0005, 16'hFFFE});
    tbl.push_back('{4'd2,  6'd10, 16'hF0F0, 16'hFF00, 16'hF000});
    tbl.push_back('{4'd3,  6'd11, 16'hF0F0, 16'h0F0F, 16'hFFFF});
    tbl.push_back('{4'd4,  6'd12, 16'hAAAA, 16'hFFFF, 16'h5555});
    tbl.push_back('{4'd5,  6'd13, 16'h0001, 16'h0011, 16'h0002});
    tbl.push_back('{4'd6,  6'd14, 16'h8000, 16'h000F, 16'h0001});
    tbl.push_back('{4'd7,  6'd2,  16'hFFFF, 16'h0001, 16'h0001});
    tbl.push_back('{4'd7,  6'd3,  16'h0001, 16'hFFFF, 16'h0000});
    tbl.push_back('{4'd12, 6'd0,  16'h1234, 16'h5678, 16'h0000});
    tbl.push_back('{4'd15, 6'd63, 16'hFFFF, 16'hFFFF, 16'h0000});
`ifndef MUL_EXEC_EN
    tbl.push_back('{4'd8,  6'd4,  16'h0003, 16'h0005, 16'h0000});
`endif

    // Reset held two cycles with a valid op presented
    step(1'b1, 4'd0, 6'd5, 16'h1111, 16'h2222, 1'b0, 1'b1);
    check("rst_fwd0", 32'(forward_out), 32'h0);
    step(1'b1, 4'd0, 6'd5, 16'h1111, 16'h2222, 1'b0, 1'b1);
    check("rst_fwd1", 32'(forward_out), 32'h0);
    check("rst_ready", 32'(in_ready), 32'h1);
    idle();
    check("post_rst_fwd", 32'(forward_out), 32'h0);

    // Directed table: one op, broadcast next edge, gone the edge after
    foreach (tbl[i]) begin
      step(1'b1, tbl[i].op, tbl[i].tag, tbl[i].a, tbl[i].b, 1'b0, 1'b0);
      idle();
      check($sformatf("tbl%0d_fwd", i), 32'(forward_out), 32'({1'b1, tbl[i].tag, tbl[i].exp_val}));
      idle();
      check($sformatf("tbl%0d_clr", i), 32'(forward_out[22]), 32'h0);
    end
    check("add_pattern", 32'({1'b1, 6'd5, 16'h8000}), 32'h458000 + 32'(forward_out));

    // Back-to-back SUB then SLT
    step(1'b1, 4'd1, 6'd1, 16'h0003, 16'h0005, 1'b0, 1'b0);
    step(1'b1, 4'd7, 6'd2, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    check("b2b_sub", 32'(forward_out), 32'({1'b1, 6'd1, 16'hFFFE}));
    idle();
    check("b2b_slt", 32'(forward_out), 32'({1'b1, 6'd2, 16'h0001}));
    idle();

    // Flush with an ALU op in s1; the op offered in the flush cycle is dropped
    step(1'b1, 4'd0, 6'd20, 16'h0100, 16'h0200, 1'b0, 1'b0);
    step(1'b1, 4'd0, 6'd21, 16'h0001, 16'h0001, 1'b1, 1'b0);
    check("flush_alu_fwd", 32'(forward_out), 32'h0);
    check("flush_alu_rdy", 32'(in_ready), 32'h1);
    idle();
    check("flush_alu_after", 32'(forward_out), 32'h0);

`ifdef MUL_EXEC_EN
    // 300*300 = 90000 -> low 16 bits 0x5F90, result at E+17
    step(1'b1, 4'd8, 6'd9, 16'd300, 16'd300, 1'b0, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      idle();
      check($sformatf("mul_rdy_low%0d", k), 32'(in_ready), 32'h0);
      check($sformatf("mul_quiet%0d", k), 32'(forward_out[22]), 32'h0);
    end
    idle();
    check("mul_result", 32'(forward_out), 32'({1'b1, 6'd9, 16'h5F90}));
    check("mul_rdy_back", 32'(in_ready), 32'h1);
    idle();

    // Flush mid-iteration suppresses the product
    step(1'b1, 4'd8, 6'd30, 16'h1234, 16'h0007, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) idle();
    step(1'b0, 4'd0, 6'd0, 16'h0, 16'h0, 1'b1, 1'b0);
    check("flush_mul_rdy", 32'(in_ready), 32'h1);
    for (int k = 0; k < 18; k++) begin
      idle();
      check($sformatf("flush_mul_quiet%0d", k), 32'(forward_out[22]), 32'h0);
    end

    // Reset mid-multiply
    step(1'b1, 4'd8, 6'd31, 16'h0005, 16'h0005, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) idle();
    step(1'b0, 4'd0, 6'd0, 16'h0, 16'h0, 1'b0, 1'b1);
    for (int k = 0; k < 18; k++) idle();
`endif

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      step(($urandom % 4) != 0, 4'($urandom), 6'($urandom), 16'($urandom), 16'($urandom),
           ($urandom % 40) == 0, ($urandom % 150) == 0);
    end
    for (int k = 0; k < 20; k++) idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
